rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Round-robin arbiter for the 2nd-level parser distribution path: picks one requester out of WIDTH ready parsers and returns a one-hot grant.
- Grant is combinational from req and a one-hot priority pointer (base); base is held in an internal register.
- On each accepted transfer (advance asserted while any req is set), base takes the current grant. The parser just granted keeps top priority while it stays ready.

Parameters:
- WIDTH, 6, number of requesters (>=2).
- BASE_INIT, {{(WIDTH-1){1'b0}},1'b1}, one-hot reset value of the priority pointer (bit 0 by default).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  WIDTH  per-requester ready/request, bit i = requester i.
- advance  input  1  transfer accepted this cycle; allows pointer update.
- grant  output  WIDTH  one-hot grant, combinational; all-zero when req==0.
- grant_valid  output  1  combinational, equals |req.
- base  output  WIDTH  current one-hot priority pointer (register value).

Behaviour:
- Priority: search starts at the bit position set in base (inclusive) and moves upward through the bits, wrapping from WIDTH-1 to 0. The first set req bit is granted.
- Reference implementation: dreq={req,req}; dg=dreq & ~(dreq - {0,base}); grant=dg[WIDTH-1:0] | dg[2W-1:W]. Any equivalent logic is acceptable.
- grant has at most one bit set. grant==0 iff req==0. grant is a subset of req.
- Zero latency: a change in req is reflected in grant in the same cycle, with no register in the path.
- Pointer register:
  - rst asserted (any time, asynchronously): base <= BASE_INIT immediately. grant is then recomputed from the new base.
  - rising clk with advance==1 and req!=0: base <= grant.
  - otherwise: base holds.
- advance with req==0: no change. advance is ignored while rst is high.
- base stays one-hot by construction: BASE_INIT is one-hot and grant is one-hot when loaded.
- BASE_INIT must be one-hot. A non-one-hot value is a configuration error, and a simulation-time assertion must flag it.
- Wrap-around: base at the MSB with only low bits requesting grants the lowest set req bit.
- No other state. The block owns no data path; the caller gates valid_out = valid_in ? grant : 0 externally.

Decomposition:
- Shared package: function onehot_check(WIDTH) used by the assertion; a localparam default for BASE_INIT.
- One sub-module is natural: rr_pick (pure combinational double-width subtract pick, inputs req/base, output grant). rr_arbiter wraps it together with the pointer register.

Test Plan:
- Reset, then req=6'b111111, advance=0 -> base=6'b000001, grant=6'b000001, grant_valid=1; repeated clocks leave base unchanged.
- base=6'b000001, req=6'b101100 -> grant=6'b000100. Pulse advance -> base=6'b000100. Then req=6'b101000 -> grant=6'b001000.
- Wrap: base=6'b100000 (reached via advances), req=6'b000110 -> grant=6'b000010. Advance -> base=6'b000010.
- Inclusive priority: base=6'b000100, req=6'b111111 -> grant=6'b000100. Advance keeps base=6'b000100.
- req=0 with advance=1 for several cycles -> grant=0, grant_valid=0, base unchanged.
- Assert rst asynchronously between clock edges while base=6'b010000 -> base becomes 6'b000001 before the next edge. Advance during rst has no effect. Randomized req: grant is a subset of req and $onehot0(grant) holds every cycle.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_pkg
// Brief    : Shared constants and configuration helper for the round-robin arbiter.
// Revision : 1.0
// ============================================================================
package rr_arbiter_pkg;

  localparam int c_default_width = 6;
  localparam int c_max_width     = 64;
  localparam logic [c_default_width-1:0] c_default_base_init = 6'b000001;

  // True when exactly one of the low 'width' bits of vec is set.
  function automatic bit onehot_check(input logic [c_max_width-1:0] vec, input int width);
    int ones;
    ones = 0;
    for (int i = 0; i < c_max_width; i++) begin
      if (i < width && vec[i]) ones++;
    end
    return (ones == 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_if
// Brief    : Request/grant bundle between parser requesters and the arbiter.
// Revision : 1.0
// ============================================================================
interface rr_arbiter_if
  import rr_arbiter_pkg::*;
#(
  parameter int WIDTH = c_default_width
) ();

  logic [WIDTH-1:0] req;
  logic             advance;
  logic [WIDTH-1:0] grant;
  logic             grant_valid;
  logic [WIDTH-1:0] base;

  modport master (
    output req,
    output advance,
    input  grant,
    input  grant_valid,
    input  base
  );

  modport slave (
    input  req,
    input  advance,
    output grant,
    output grant_valid,
    output base
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin pick: first set req at or above base, wrapping.
// Revision : 1.0
// ============================================================================
module rr_pick
  import rr_arbiter_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] base,
  output logic [WIDTH-1:0] grant
);

  logic [2*WIDTH-1:0] w_dreq;
  logic [2*WIDTH-1:0] w_dg;

  // The borrow from subtracting base clears the first set request at or above
  // base; the doubled copy lets that search wrap past the MSB.
  assign w_dreq = {req, req};
  assign w_dg   = w_dreq & ~(w_dreq - {{WIDTH{1'b0}}, base});
  assign grant  = w_dg[WIDTH-1:0] | w_dg[2*WIDTH-1:WIDTH];

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter with one-hot priority pointer updated on advance.
// Revision : 1.0
// ============================================================================
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int               WIDTH     = c_default_width,
  parameter logic [WIDTH-1:0] BASE_INIT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic       clk,
  input  logic       rst,
  rr_arbiter_if.slave arb
);

  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] w_grant;
  logic             w_any_req;

  rr_pick #(
    .WIDTH (WIDTH)
  ) u_pick (
    .req   (arb.req),
    .base  (r_base),
    .grant (w_grant)
  );

  assign w_any_req = |arb.req;

  // The granted requester becomes the new pointer, so it keeps top priority
  // for as long as it stays ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= BASE_INIT;
    end else if (arb.advance && w_any_req) begin
      r_base <= w_grant;
    end
  end

  always_ff @(posedge clk) begin : p_cfg_check
    assert (onehot_check(c_max_width'(BASE_INIT), WIDTH))
      else $error("rr_arbiter: BASE_INIT %b is not one-hot", BASE_INIT);
  end

  assign arb.grant       = w_grant;
  assign arb.grant_valid = w_any_req;
  assign arb.base        = r_base;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter
// Brief    : Directed and randomized self-checking bench for rr_arbiter.
// Revision : 1.0
// ============================================================================
module tb_rr_arbiter;
  import rr_arbiter_pkg::*;

  localparam int W = 6;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  rr_arbiter_if #(.WIDTH(W)) arb_if ();

  rr_arbiter #(
    .WIDTH     (W),
    .BASE_INIT (6'b000001)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .arb (arb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  // Independent search model: scan upward from the pointer position.
  function automatic logic [W-1:0] ref_pick(input logic [W-1:0] r, input logic [W-1:0] b);
    int start;
    int idx;
    logic [W-1:0] g;
    start = 0;
    g = '0;
    for (int i = 0; i < W; i++) if (b[i]) start = i;
    for (int k = W - 1; k >= 0; k--) begin
      idx = (start + k) % W;
      if (r[idx]) begin
        g = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  // Drive new inputs on the falling edge, let the comb path settle.
  task automatic drive(input logic [W-1:0] r, input logic a);
    @(negedge clk);
    arb_if.req     = r;
    arb_if.advance = a;
    #1;
  endtask

  // One accepted transfer: advance across one rising edge, then drop it.
  task automatic pulse_advance();
    arb_if.advance = 1'b1;
    @(negedge clk);
    arb_if.advance = 1'b0;
    #1;
  endtask

  initial begin
    logic [W-1:0] m_base;
    logic [W-1:0] r;
    logic [W-1:0] eg;
    logic         a;

    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    arb_if.req     = '0;
    arb_if.advance = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    drive(6'b111111, 1'b0);
    chk("reset_base", arb_if.base, 6'b000001);
    chk("reset_grant", arb_if.grant, 6'b000001);
    chk1("reset_gvalid", arb_if.grant_valid, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("hold_no_advance", arb_if.base, 6'b000001);

    drive(6'b101100, 1'b0);
    chk("pick_above_base", arb_if.grant, 6'b000100);
    pulse_advance();
    chk("adv_base_000100", arb_if.base, 6'b000100);
    drive(6'b101000, 1'b0);
    chk("pick_next_up", arb_if.grant, 6'b001000);

    drive(6'b111111, 1'b0);
    chk("inclusive_grant", arb_if.grant, 6'b000100);
    pulse_advance();
    chk("inclusive_keep_base", arb_if.base, 6'b000100);

    drive(6'b100000, 1'b0);
    chk("msb_grant", arb_if.grant, 6'b100000);
    pulse_advance();
    chk("base_at_msb", arb_if.base, 6'b100000);
    drive(6'b000110, 1'b0);
    chk("wrap_grant", arb_if.grant, 6'b000010);
    pulse_advance();
    chk("wrap_base", arb_if.base, 6'b000010);

    drive(6'b000000, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("idle_grant", arb_if.grant, 6'b000000);
    chk1("idle_gvalid", arb_if.grant_valid, 1'b0);
    chk("idle_base_hold", arb_if.base, 6'b000010);

    drive(6'b010000, 1'b0);
    pulse_advance();
    chk("base_010000", arb_if.base, 6'b010000);

    // Asynchronous reset mid-cycle, with advance requested throughout.
    @(posedge clk);
    #2;
    arb_if.req     = 6'b111111;
    arb_if.advance = 1'b1;
    rst            = 1'b1;
    #1;
    chk("async_rst_base", arb_if.base, 6'b000001);
    chk("async_rst_grant", arb_if.grant, 6'b000001);
    arb_if.req = 6'b010000;
    @(posedge clk);
    #1;
    chk("adv_ignored_in_rst", arb_if.base, 6'b000001);
    chk("rst_grant_010000", arb_if.grant, 6'b010000);
    @(negedge clk);
    rst            = 1'b0;
    arb_if.advance = 1'b0;
    #1;
    chk("after_rst_base", arb_if.base, 6'b000001);

    m_base = 6'b000001;
    for (int n = 0; n < 150; n++) begin
      r  = W'($urandom_range(0, (1 << W) - 1));
      a  = 1'($urandom_range(0, 1));
      drive(r, a);
      eg = ref_pick(r, m_base);
      chk("rand_grant", arb_if.grant, eg);
      chk("rand_base", arb_if.base, m_base);
      chk1("rand_subset_onehot0",
           ((arb_if.grant & ~r) == '0) && $onehot0(arb_if.grant), 1'b1);
      chk1("rand_gvalid", arb_if.grant_valid, |r);
      @(posedge clk);
      if (a && (r != '0)) m_base = eg;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
